// File: rtl/wb_nn_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the wishbone_nn slave.
// A stalled owner is aborted after TIMEOUT unacknowledged strobe cycles.
module wb_nn_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic [7:0]  abort_cnt_o
);

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] THRESH  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t          state_r;
  logic            owner_r;
  logic            last_r;
  logic [CW-1:0]   stall_cnt_r;
  logic            err_r;
  logic [7:0]      abort_cnt_r;

  logic            req0_s;
  logic            req1_s;
  logic            owner_cyc_s;
  logic            owner_stb_s;

  assign req0_s      = m0_cyc_i & m0_stb_i;
  assign req1_s      = m1_cyc_i & m1_stb_i;
  assign owner_cyc_s = owner_r ? m1_cyc_i : m0_cyc_i;
  assign owner_stb_s = owner_r ? m1_stb_i : m0_stb_i;
  assign abort_cnt_o = abort_cnt_r;

  // Slave bus mux, master response routing and grant decode.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = 32'h0;
    grant_o  = 2'b00;
    case (state_r)
      BUSY: begin
        grant_o = owner_r ? 2'b10 : 2'b01;
        if (owner_r) begin
          s_cyc_o  = m1_cyc_i;
          s_stb_o  = m1_stb_i;
          s_we_o   = m1_we_i;
          s_sel_o  = m1_sel_i;
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          m1_ack_o = s_ack_i;
          m1_dat_o = s_dat_i;
        end else begin
          s_cyc_o  = m0_cyc_i;
          s_stb_o  = m0_stb_i;
          s_we_o   = m0_we_i;
          s_sel_o  = m0_sel_i;
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          m0_ack_o = s_ack_i;
          m0_dat_o = s_dat_i;
        end
      end
      ABORT: begin
        grant_o  = owner_r ? 2'b10 : 2'b01;
        m0_err_o = err_r & ~owner_r;
        m1_err_o = err_r & owner_r;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

  // Arbitration FSM with stall watchdog and abort statistics.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      stall_cnt_r <= '0;
      err_r       <= 1'b0;
      abort_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          stall_cnt_r <= '0;
          err_r       <= 1'b0;
          if (req0_s && req1_s) begin
            owner_r <= ~last_r;
            state_r <= BUSY;
          end else if (req0_s || req1_s) begin
            owner_r <= req1_s;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          err_r <= 1'b0;
          // Release beats a coincident timeout threshold.
          if (!owner_cyc_s) begin
            last_r      <= owner_r;
            stall_cnt_r <= '0;
            state_r     <= IDLE;
          end else if (s_ack_i) begin
            stall_cnt_r <= '0;
          end else if (owner_stb_s) begin
            if ((TIMEOUT != 0) && (stall_cnt_r == THRESH)) begin
              state_r     <= ABORT;
              err_r       <= 1'b1;
              last_r      <= owner_r;
              stall_cnt_r <= '0;
              if (abort_cnt_r != 8'hFF) begin
                abort_cnt_r <= abort_cnt_r + 8'd1;
              end else begin
                abort_cnt_r <= abort_cnt_r;
              end
            end else begin
              stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
          end else begin
            stall_cnt_r <= stall_cnt_r;
          end
        end
        ABORT: begin
          err_r       <= 1'b0;
          stall_cnt_r <= '0;
          if (!owner_cyc_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= ABORT;
          end
        end
        default: begin
          state_r     <= IDLE;
          err_r       <= 1'b0;
          stall_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_nn_arbiter.sv
// Directed bench for wb_nn_arbiter: one DUT with TIMEOUT=4, one with the
// watchdog disabled, sharing the same master and slave stimulus.
module tb_wb_nn_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat;
  logic        s_ack;
  logic [31:0] s_rdat;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [1:0]  grant;
  logic [7:0]  abort_cnt;

  logic        nt_m0_ack, nt_m0_err, nt_m1_ack, nt_m1_err;
  logic [31:0] nt_m0_rdat, nt_m1_rdat;
  logic        nt_s_cyc, nt_s_stb, nt_s_we;
  logic [3:0]  nt_s_sel;
  logic [31:0] nt_s_adr, nt_s_wdat;
  logic [1:0]  nt_grant;
  logic [7:0]  nt_abort_cnt;

  int n_vec = 0;
  int n_err = 0;

  wb_nn_arbiter #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant), .abort_cnt_o(abort_cnt)
  );

  wb_nn_arbiter #(.TIMEOUT(0)) dut_nt (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
    .m0_ack_o(nt_m0_ack), .m0_err_o(nt_m0_err), .m0_dat_o(nt_m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
    .m1_ack_o(nt_m1_ack), .m1_err_o(nt_m1_err), .m1_dat_o(nt_m1_rdat),
    .s_cyc_o(nt_s_cyc), .s_stb_o(nt_s_stb), .s_we_o(nt_s_we), .s_sel_o(nt_s_sel),
    .s_adr_o(nt_s_adr), .s_dat_o(nt_s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(nt_grant), .abort_cnt_o(nt_abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0;
    m0_adr = 32'h0; m0_wdat = 32'h0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0;
    m1_adr = 32'h0; m1_wdat = 32'h0;
    s_ack = 1'b0; s_rdat = 32'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [151:0] outs;
    clear_inputs();
    rst_n = 1'b0;
    s_ack = 1'b1;
    s_rdat = 32'hFFFF_FFFF;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    outs = {s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat, m0_ack, m0_err, m0_rdat,
            m1_ack, m1_err, m1_rdat, grant, abort_cnt};
    n_vec++;
    if (outs !== 152'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF;
    m0_adr = 32'h3000_0000; m0_wdat = 32'hCAFE_0001;
    #1;
    n_vec++;
    if (s_stb !== 1'b0) begin
      n_err++;
      $display("FAIL sw_no_stb_before_edge: got %b want 0", s_stb);
    end
    step();
    n_vec++;
    if ({s_cyc, s_stb, s_we, s_sel, grant} !== {1'b1, 1'b1, 1'b1, 4'hF, 2'b01}) begin
      n_err++;
      $display("FAIL sw_ctrl: got %b%b%b %h %b want 111 f 01", s_cyc, s_stb, s_we, s_sel, grant);
    end
    n_vec++;
    if ({s_adr, s_wdat} !== {32'h3000_0000, 32'hCAFE_0001}) begin
      n_err++;
      $display("FAIL sw_addr_data: got %h %h want 30000000 cafe0001", s_adr, s_wdat);
    end
    step();
    step();
    s_ack = 1'b1;
    s_rdat = 32'hA5A5_5A5A;
    #1;
    n_vec++;
    if ({m0_ack, m1_ack, m1_rdat} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL sw_ack: got m0_ack=%b m1_ack=%b m1_dat=%h want 1 0 0", m0_ack, m1_ack, m1_rdat);
    end
    step();
    s_ack = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    n_vec++;
    if ({s_cyc, grant} !== {1'b0, 2'b01}) begin
      n_err++;
      $display("FAIL sw_release_same_cycle: got cyc=%b grant=%b want 0 01", s_cyc, grant);
    end
    step();
    n_vec++;
    if (grant !== 2'b00) begin
      n_err++;
      $display("FAIL sw_idle: got grant=%b want 00", grant);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    n_vec++;
    if (grant !== 2'b01) begin
      n_err++;
      $display("FAIL rr_first: got grant=%b want 01", grant);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    n_vec++;
    if (grant !== 2'b00) begin
      n_err++;
      $display("FAIL rr_idle_gap: got grant=%b want 00", grant);
    end
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    n_vec++;
    if (grant !== 2'b10) begin
      n_err++;
      $display("FAIL rr_second: got grant=%b want 10", grant);
    end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    n_vec++;
    if (grant !== 2'b01) begin
      n_err++;
      $display("FAIL rr_third: got grant=%b want 01", grant);
    end
  endtask

  task automatic test_read_mux();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_we = 1'b0; m1_sel = 4'hF; m1_adr = 32'h3000_0010;
    step();
    step();
    n_vec++;
    if ({grant, s_we, s_adr} !== {2'b10, 1'b0, 32'h3000_0010}) begin
      n_err++;
      $display("FAIL rd_grant: got grant=%b we=%b adr=%h want 10 0 30000010", grant, s_we, s_adr);
    end
    s_rdat = 32'h1234_5678;
    s_ack = 1'b1;
    #1;
    n_vec++;
    if ({m1_ack, m1_rdat, m0_ack, m0_rdat} !== {1'b1, 32'h1234_5678, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL rd_mux: got m1 %b %h m0 %b %h want 1 12345678 0 0", m1_ack, m1_rdat, m0_ack, m0_rdat);
    end
    step();
    s_ack = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    step();
    step();
    step();
    n_vec++;
    if ({m0_err, s_cyc, abort_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL to_fourth_stall: got err=%b cyc=%b cnt=%0d want 0 1 0", m0_err, s_cyc, abort_cnt);
    end
    step();
    n_vec++;
    if ({m0_err, s_cyc, s_stb, grant, abort_cnt} !== {1'b1, 1'b0, 1'b0, 2'b01, 8'd1}) begin
      n_err++;
      $display("FAIL to_abort: got err=%b cyc=%b stb=%b grant=%b cnt=%0d want 1 0 0 01 1",
               m0_err, s_cyc, s_stb, grant, abort_cnt);
    end
    s_ack = 1'b1;
    #1;
    n_vec++;
    if (m0_ack !== 1'b0) begin
      n_err++;
      $display("FAIL to_late_ack: got m0_ack=%b want 0", m0_ack);
    end
    step();
    n_vec++;
    if ({m0_err, grant} !== {1'b0, 2'b01}) begin
      n_err++;
      $display("FAIL to_err_one_cycle: got err=%b grant=%b want 0 01", m0_err, grant);
    end
    s_ack = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    for (int i = 0; i < 299; i++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1;
      repeat (5) step();
      m0_cyc = 1'b0; m0_stb = 1'b0;
      step();
    end
    n_vec++;
    if (abort_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL to_saturate: got cnt=%0d want 255", abort_cnt);
    end
  endtask

  task automatic test_boundaries();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    step();
    step();
    step();
    s_ack = 1'b1;
    #1;
    n_vec++;
    if (m0_ack !== 1'b1) begin
      n_err++;
      $display("FAIL bd_ack_at_threshold: got m0_ack=%b want 1", m0_ack);
    end
    step();
    s_ack = 1'b0;
    #1;
    n_vec++;
    if ({m0_err, s_cyc, grant, abort_cnt} !== {1'b0, 1'b1, 2'b01, 8'd0}) begin
      n_err++;
      $display("FAIL bd_ack_wins: got err=%b cyc=%b grant=%b cnt=%0d want 0 1 01 0",
               m0_err, s_cyc, grant, abort_cnt);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    step();
    step();
    step();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    n_vec++;
    if ({m0_err, grant, abort_cnt} !== {1'b0, 2'b00, 8'd0}) begin
      n_err++;
      $display("FAIL bd_release_wins: got err=%b grant=%b cnt=%0d want 0 00 0", m0_err, grant, abort_cnt);
    end
  endtask

  task automatic test_no_timeout();
    logic err_seen;
    apply_reset();
    err_seen = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    for (int i = 0; i < 1000; i++) begin
      err_seen = err_seen | nt_m0_err;
      step();
    end
    n_vec++;
    if ({err_seen, nt_s_cyc, nt_grant, nt_abort_cnt} !== {1'b0, 1'b1, 2'b01, 8'd0}) begin
      n_err++;
      $display("FAIL nt_no_abort: got err_seen=%b cyc=%b grant=%b cnt=%0d want 0 1 01 0",
               err_seen, nt_s_cyc, nt_grant, nt_abort_cnt);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    n_vec++;
    if ({s_cyc, m0_ack} !== 2'b11) begin
      n_err++;
      $display("FAIL rm_busy: got cyc=%b ack=%b want 1 1", s_cyc, m0_ack);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_cyc, s_stb, grant, m0_ack, m0_err, m1_ack} !== 7'b0) begin
      n_err++;
      $display("FAIL rm_async: got cyc=%b stb=%b grant=%b ack=%b err=%b m1_ack=%b want all 0",
               s_cyc, s_stb, grant, m0_ack, m0_err, m1_ack);
    end
    s_ack = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if ({grant, m0_err} !== {2'b01, 1'b0}) begin
      n_err++;
      $display("FAIL rm_tie_after_reset: got grant=%b err=%b want 01 0", grant, m0_err);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_single_write();
    test_contention();
    test_read_mux();
    test_timeout();
    test_boundaries();
    test_no_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
